// File: rtl/psum_output_packer.sv
// psum_output_packer
//   Packs four per-kernel psum byte streams into OUT_WIDTH words, buffers
//   each lane in a small FIFO and merges the lanes round-robin onto one
//   valid/ready write stream tagged with the kernel index. When i_conf_cnt
//   is non-zero, each lane closes its output map after that many psums.
//   A partial word is flushed zero-padded, and o_done pulses once all lanes
//   have finished and drained.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   i_psum_kn0..3        psum byte per kernel lane
//   i_psum_kn0..3_val    psum valid per lane (no backpressure)
//   i_conf_cnt           [15:0] psums per kernel per map, 0 = never flush
//   o_wdata/_kn/_val     packed word, its lane index, valid
//   i_wdata_rdy          downstream ready
//   o_done               one-cycle end-of-map pulse
//   o_overflow           sticky: a word was dropped on a full lane FIFO
module psum_output_packer #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int REG_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] i_psum_kn0,
    input  logic [BIT_WIDTH-1:0] i_psum_kn1,
    input  logic [BIT_WIDTH-1:0] i_psum_kn2,
    input  logic [BIT_WIDTH-1:0] i_psum_kn3,
    input  logic                 i_psum_kn0_val,
    input  logic                 i_psum_kn1_val,
    input  logic                 i_psum_kn2_val,
    input  logic                 i_psum_kn3_val,
    input  logic [REG_WIDTH-1:0] i_conf_cnt,
    output logic [OUT_WIDTH-1:0] o_wdata,
    output logic [1:0]           o_wdata_kn,
    output logic                 o_wdata_val,
    input  logic                 i_wdata_rdy,
    output logic                 o_done,
    output logic                 o_overflow
);

    localparam int BYTES = OUT_WIDTH / BIT_WIDTH;
    localparam int BW    = $clog2(BYTES);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int KW    = $clog2(NUM_KERNEL);

    logic [BIT_WIDTH-1:0]  psum [NUM_KERNEL];
    logic [NUM_KERNEL-1:0] psum_val;

    assign psum[0]  = i_psum_kn0;
    assign psum[1]  = i_psum_kn1;
    assign psum[2]  = i_psum_kn2;
    assign psum[3]  = i_psum_kn3;
    assign psum_val = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};

    logic [15:0] cnt16;
    logic        flush_en;
    logic        unused_conf;

    assign cnt16       = i_conf_cnt[15:0];
    assign flush_en    = (cnt16 != 16'd0);
    assign unused_conf = ^i_conf_cnt[REG_WIDTH-1:16];

    // Lane packing state
    logic [OUT_WIDTH-1:0]  pack_q     [NUM_KERNEL];
    logic [BW-1:0]         byte_idx   [NUM_KERNEL];
    logic [15:0]           psum_cnt   [NUM_KERNEL];
    logic [NUM_KERNEL-1:0] lane_done;
    logic [OUT_WIDTH-1:0]  stage_word [NUM_KERNEL];
    logic [NUM_KERNEL-1:0] stage_vld;

    logic [OUT_WIDTH-1:0]  merged     [NUM_KERNEL];
    logic [NUM_KERNEL-1:0] take;
    logic [NUM_KERNEL-1:0] last_psum;
    logic [NUM_KERNEL-1:0] push_now;

    // Lane FIFOs and output arbitration
    logic [OUT_WIDTH-1:0]  fifo_mem [NUM_KERNEL][FIFO_DEPTH];
    logic [AW:0]           wr_ptr   [NUM_KERNEL];
    logic [AW:0]           rd_ptr   [NUM_KERNEL];
    logic [NUM_KERNEL-1:0] fifo_empty;
    logic [NUM_KERNEL-1:0] fifo_full;
    logic [NUM_KERNEL-1:0] pop;
    logic [NUM_KERNEL-1:0] push_ok;
    logic                  overflow_set;

    logic [KW-1:0]         rr_ptr;
    logic [KW-1:0]         sel;
    logic                  sel_found;
    logic                  out_load;
    logic                  done_fire;

    // Pending bytes above byte_idx are always zero, so OR-ing the new byte in
    // also yields the zero-padded word needed by a partial flush.
    always_comb begin
        for (int unsigned k = 0; k < NUM_KERNEL; k++) begin
            take[k]      = psum_val[k] & ~lane_done[k];
            merged[k]    = pack_q[k] |
                           ({{(OUT_WIDTH-BIT_WIDTH){1'b0}}, psum[k]} << (BIT_WIDTH * int'(byte_idx[k])));
            last_psum[k] = flush_en & ((psum_cnt[k] + 16'd1) == cnt16);
            push_now[k]  = take[k] & ((byte_idx[k] == BW'(BYTES-1)) | last_psum[k]);
        end
    end

    // A finished word is staged one cycle before entering the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_vld <= '0;
            lane_done <= '0;
            for (int unsigned k = 0; k < NUM_KERNEL; k++) begin
                pack_q[k]     <= '0;
                byte_idx[k]   <= '0;
                psum_cnt[k]   <= '0;
                stage_word[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_KERNEL; k++) begin
                stage_vld[k] <= push_now[k];
                if (push_now[k]) begin
                    stage_word[k] <= merged[k];
                end
                if (take[k]) begin
                    if (push_now[k]) begin
                        pack_q[k]   <= '0;
                        byte_idx[k] <= '0;
                    end else begin
                        pack_q[k]   <= merged[k];
                        byte_idx[k] <= byte_idx[k] + BW'(1);
                    end
                    if (flush_en) begin
                        psum_cnt[k] <= psum_cnt[k] + 16'd1;
                    end
                    if (last_psum[k]) begin
                        lane_done[k] <= 1'b1;
                    end
                end
                if (done_fire) begin
                    psum_cnt[k]  <= '0;
                    lane_done[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_KERNEL; k++) begin
            fifo_empty[k] = (wr_ptr[k] == rd_ptr[k]);
            fifo_full[k]  = ((wr_ptr[k] - rd_ptr[k]) == (AW+1)'(FIFO_DEPTH));
        end
    end

    // First non-empty lane at or after rr_ptr, wrapping.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NUM_KERNEL; i++) begin
            if (!sel_found && !fifo_empty[rr_ptr + KW'(i)]) begin
                sel       = rr_ptr + KW'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign out_load = ~o_wdata_val | i_wdata_rdy;

    // A full FIFO still accepts a push when the same lane is popped this cycle.
    always_comb begin
        for (int unsigned k = 0; k < NUM_KERNEL; k++) begin
            pop[k]     = out_load & sel_found & (sel == KW'(k));
            push_ok[k] = stage_vld[k] & (~fifo_full[k] | pop[k]);
        end
        overflow_set = |(stage_vld & ~push_ok);
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_KERNEL; k++) begin
            if (push_ok[k]) begin
                fifo_mem[k][wr_ptr[k][AW-1:0]] <= stage_word[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NUM_KERNEL; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_KERNEL; k++) begin
                if (push_ok[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + (AW+1)'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + (AW+1)'(1);
                end
            end
        end
    end

    assign done_fire = flush_en & (&lane_done) & (&fifo_empty) & ~(|stage_vld) & ~o_wdata_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_wdata     <= '0;
            o_wdata_kn  <= '0;
            o_wdata_val <= 1'b0;
            rr_ptr      <= '0;
            o_done      <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_done <= done_fire;
            if (overflow_set) begin
                o_overflow <= 1'b1;
            end
            if (out_load) begin
                o_wdata_val <= sel_found;
                if (sel_found) begin
                    o_wdata    <= fifo_mem[sel][rd_ptr[sel][AW-1:0]];
                    o_wdata_kn <= sel;
                    rr_ptr     <= sel + KW'(1);
                end
            end
            if (done_fire) begin
                rr_ptr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_psum_output_packer.sv
// tb_psum_output_packer
//   Directed bench for psum_output_packer: a per-cycle vector table covering
//   two complete output maps (full words, then a zero-padded flush), plus
//   hand-written sequences for reset, round-robin order, backpressure with
//   overflow, and asynchronous reset mid-word.
module tb_psum_output_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  p0, p1, p2, p3;
    logic [3:0]  pv;
    logic [31:0] conf_cnt;
    logic [31:0] o_wdata;
    logic [1:0]  o_wdata_kn;
    logic        o_wdata_val;
    logic        rdy;
    logic        o_done;
    logic        o_overflow;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] got_data [$];
    logic [1:0]  got_kn   [$];
    logic [31:0] exp_data [$];
    logic [1:0]  exp_kn   [$];

    always #5 clk = ~clk;

    psum_output_packer #(
        .BIT_WIDTH (8),
        .NUM_KERNEL(4),
        .OUT_WIDTH (32),
        .FIFO_DEPTH(4),
        .REG_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_psum_kn0    (p0),
        .i_psum_kn1    (p1),
        .i_psum_kn2    (p2),
        .i_psum_kn3    (p3),
        .i_psum_kn0_val(pv[0]),
        .i_psum_kn1_val(pv[1]),
        .i_psum_kn2_val(pv[2]),
        .i_psum_kn3_val(pv[3]),
        .i_conf_cnt    (conf_cnt),
        .o_wdata       (o_wdata),
        .o_wdata_kn    (o_wdata_kn),
        .o_wdata_val   (o_wdata_val),
        .i_wdata_rdy   (rdy),
        .o_done        (o_done),
        .o_overflow    (o_overflow)
    );

    typedef struct {
        logic [15:0] cnt;
        logic [3:0]  val;
        logic [7:0]  idx;
        logic        rdy;
        logic        exp_val;
        logic [1:0]  exp_kn;
        logic [31:0] exp_data;
        logic        exp_done;
    } vec_t;

    vec_t vecs [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        pv = v;
        p0 = b0;
        p1 = b1;
        p2 = b2;
        p3 = b3;
    endtask

    // Records a word if the current output is being accepted at the next edge.
    task automatic collect();
        if (o_wdata_val && rdy) begin
            got_data.push_back(o_wdata);
            got_kn.push_back(o_wdata_kn);
        end
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s_kn%0d", tag, i), 32'(got_kn[i]), 32'(exp_kn[i]));
        end
        got_data.delete();
        got_kn.delete();
        exp_data.delete();
        exp_kn.delete();
    endtask

    function automatic logic [31:0] mk_word(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic set_vec(input int i, input logic [15:0] cnt, input logic [3:0] val,
                           input logic [7:0] idx, input logic ev, input logic [1:0] kn,
                           input logic [31:0] data, input logic done);
        vecs[i].cnt      = cnt;
        vecs[i].val      = val;
        vecs[i].idx      = idx;
        vecs[i].rdy      = 1'b1;
        vecs[i].exp_val  = ev;
        vecs[i].exp_kn   = kn;
        vecs[i].exp_data = data;
        vecs[i].exp_done = done;
    endtask

    initial begin
        // Map A: cnt=8, all lanes bytes k*16+1..8; every word full.
        for (int i = 0; i < 5; i++) set_vec(i, 16'd8, 4'hF, 8'(i + 1), 1'b0, 2'd0, 32'h0, 1'b0);
        set_vec(5,  16'd8, 4'hF, 8'd6, 1'b1, 2'd0, 32'h04030201, 1'b0);
        set_vec(6,  16'd8, 4'hF, 8'd7, 1'b1, 2'd1, 32'h14131211, 1'b0);
        set_vec(7,  16'd8, 4'hF, 8'd8, 1'b1, 2'd2, 32'h24232221, 1'b0);
        set_vec(8,  16'd8, 4'h0, 8'd0, 1'b1, 2'd3, 32'h34333231, 1'b0);
        set_vec(9,  16'd8, 4'h0, 8'd0, 1'b1, 2'd0, 32'h08070605, 1'b0);
        set_vec(10, 16'd8, 4'h0, 8'd0, 1'b1, 2'd1, 32'h18171615, 1'b0);
        set_vec(11, 16'd8, 4'h0, 8'd0, 1'b1, 2'd2, 32'h28272625, 1'b0);
        set_vec(12, 16'd8, 4'h0, 8'd0, 1'b1, 2'd3, 32'h38373635, 1'b0);
        set_vec(13, 16'd8, 4'h0, 8'd0, 1'b0, 2'd0, 32'h0, 1'b0);
        set_vec(14, 16'd8, 4'h0, 8'd0, 1'b0, 2'd0, 32'h0, 1'b1);
        set_vec(15, 16'd8, 4'h0, 8'd0, 1'b0, 2'd0, 32'h0, 1'b0);
        // Map B: cnt=6, full word then zero-padded partial per lane.
        for (int i = 16; i < 21; i++) set_vec(i, 16'd6, 4'hF, 8'(i - 15), 1'b0, 2'd0, 32'h0, 1'b0);
        set_vec(21, 16'd6, 4'hF, 8'd6, 1'b1, 2'd0, 32'h04030201, 1'b0);
        set_vec(22, 16'd6, 4'h0, 8'd0, 1'b1, 2'd1, 32'h14131211, 1'b0);
        set_vec(23, 16'd6, 4'h0, 8'd0, 1'b1, 2'd2, 32'h24232221, 1'b0);
        set_vec(24, 16'd6, 4'h0, 8'd0, 1'b1, 2'd3, 32'h34333231, 1'b0);
        set_vec(25, 16'd6, 4'h0, 8'd0, 1'b1, 2'd0, 32'h00000605, 1'b0);
        set_vec(26, 16'd6, 4'h0, 8'd0, 1'b1, 2'd1, 32'h00001615, 1'b0);
        set_vec(27, 16'd6, 4'h0, 8'd0, 1'b1, 2'd2, 32'h00002625, 1'b0);
        set_vec(28, 16'd6, 4'h0, 8'd0, 1'b1, 2'd3, 32'h00003635, 1'b0);
        set_vec(29, 16'd6, 4'h0, 8'd0, 1'b0, 2'd0, 32'h0, 1'b0);
        set_vec(30, 16'd6, 4'h0, 8'd0, 1'b0, 2'd0, 32'h0, 1'b1);
        set_vec(31, 16'd6, 4'h0, 8'd0, 1'b0, 2'd0, 32'h0, 1'b0);

        // Reset held with toggling inputs: outputs stay cleared.
        rst      = 1'b0;
        rdy      = 1'b0;
        conf_cnt = 32'd0;
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 4; i++) begin
            drive(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            rdy      = 1'($urandom);
            conf_cnt = $urandom_range(1, 12);
            tick();
            check($sformatf("rst_val%0d", i), 32'(o_wdata_val), 32'd0);
            check($sformatf("rst_data%0d", i), o_wdata, 32'd0);
            check($sformatf("rst_kn%0d", i), 32'(o_wdata_kn), 32'd0);
            check($sformatf("rst_done%0d", i), 32'(o_done), 32'd0);
            check($sformatf("rst_ovf%0d", i), 32'(o_overflow), 32'd0);
        end
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        conf_cnt = 32'd0;
        rdy      = 1'b1;
        rst      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle_val%0d", i), 32'(o_wdata_val), 32'd0);
        end

        // Table: one record per clock, outputs checked just after the edge.
        for (int i = 0; i < 32; i++) begin
            conf_cnt = {16'hA5A5, vecs[i].cnt};
            rdy      = vecs[i].rdy;
            drive(vecs[i].val,
                  vecs[i].val[0] ? 8'h00 + vecs[i].idx : 8'h0,
                  vecs[i].val[1] ? 8'h10 + vecs[i].idx : 8'h0,
                  vecs[i].val[2] ? 8'h20 + vecs[i].idx : 8'h0,
                  vecs[i].val[3] ? 8'h30 + vecs[i].idx : 8'h0);
            tick();
            check($sformatf("vec%0d_done", i), 32'(o_done), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_val", i), 32'(o_wdata_val), 32'(vecs[i].exp_val));
            if (vecs[i].exp_val) begin
                check($sformatf("vec%0d_data", i), o_wdata, vecs[i].exp_data);
                check($sformatf("vec%0d_kn", i), 32'(o_wdata_kn), 32'(vecs[i].exp_kn));
            end
        end
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);

        // Round-robin: two sets of simultaneous words, cnt=0 (no flush).
        conf_cnt = 32'd0;
        rdy      = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 4; k++) begin
                exp_data.push_back(mk_word(8'(8'h80 + k * 16 + 4 * s + 1)));
                exp_kn.push_back(2'(k));
            end
        end
        for (int i = 1; i <= 8; i++) begin
            collect();
            drive(4'hF, 8'(8'h80 + i), 8'(8'h90 + i), 8'(8'hA0 + i), 8'(8'hB0 + i));
            tick();
        end
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 14; i++) begin
            collect();
            tick();
        end
        check("rr_no_done", 32'(o_done), 32'd0);
        compare_stream("rr");

        // Backpressure: lane1 streams 24 bytes with rdy=0; 6th word dropped.
        rdy = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            drive(4'h2, 8'h0, 8'(8'h40 + i), 8'h0, 8'h0);
            tick();
        end
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        tick();
        tick();
        check("bp_ovf_early", 32'(o_overflow), 32'd0);
        for (int i = 21; i <= 24; i++) begin
            drive(4'h2, 8'h0, 8'(8'h40 + i), 8'h0, 8'h0);
            tick();
        end
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        tick();
        tick();
        check("bp_ovf_set", 32'(o_overflow), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_val%0d", i), 32'(o_wdata_val), 32'd1);
            check($sformatf("bp_hold_kn%0d", i), 32'(o_wdata_kn), 32'd1);
            check($sformatf("bp_hold_data%0d", i), o_wdata, 32'h44434241);
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            exp_data.push_back(mk_word(8'(8'h41 + 4 * j)));
            exp_kn.push_back(2'd1);
        end
        rdy = 1'b1;
        for (int i = 0; i < 15; i++) begin
            collect();
            tick();
        end
        compare_stream("bp");
        check("bp_ovf_sticky", 32'(o_overflow), 32'd1);

        // Asynchronous reset after 3 bytes on lane3, then a fresh word.
        for (int i = 1; i <= 3; i++) begin
            drive(4'h8, 8'h0, 8'h0, 8'h0, 8'(8'hE0 + i));
            tick();
        end
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        #3;
        rst = 1'b0;
        #1;
        check("arst_ovf", 32'(o_overflow), 32'd0);
        check("arst_data", o_wdata, 32'd0);
        check("arst_val", 32'(o_wdata_val), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            collect();
            drive(4'h8, 8'h0, 8'h0, 8'h0, 8'(8'hC0 + i));
            tick();
        end
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 10; i++) begin
            collect();
            tick();
        end
        exp_data.push_back(32'hC4C3C2C1);
        exp_kn.push_back(2'd3);
        compare_stream("arst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
